uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
Parametrised successor to the fixed 8N1 UART receiver. Supports 5-9 data bits, optional even/odd parity, and 1 or 2 stop bits. Uses 16x oversampling with 3-sample majority voting. Received words go into a first-word-fall-through FIFO that carries per-word error flags and a sticky overrun flag. It sits between the pad-side rx line and a host that drains words at its own pace.

Parameters:
DATA_BITS, 8, data bits per frame, 5..9, sent LSB first
PARITY, 0, parity mode: 0 none, 1 even, 2 odd
STOP_BITS, 1, stop bits expected: 1 or 2
FIFO_DEPTH_LOG2, 2, FIFO depth is 2**FIFO_DEPTH_LOG2 entries (min 1)

Ports:
clk_baud_16x  in  1  sole clock, 16x the baud rate
reset  in  1  synchronous, active-high
rx  in  1  asynchronous serial input, idle high
recv_data  out  DATA_BITS  data of the FIFO head entry
recv_frame_err  out  1  head entry stop bit(s) sampled low
recv_parity_err  out  1  head entry parity mismatch (0 when PARITY=0)
recv_valid  out  1  FIFO not empty
recv_read  in  1  pop the head entry; ignored when recv_valid=0
recv_busy  out  1  a frame is being received
recv_overrun  out  1  sticky: a completed word was dropped because the FIFO was full
recv_overrun_clear  in  1  clears recv_overrun
recv_level  out  FIFO_DEPTH_LOG2+1  current FIFO occupancy

Behaviour:
- One clock (clk_baud_16x). Reset is synchronous and active-high.
- Reset, including mid-frame: FSM goes to IDLE, FIFO is emptied, and the synchroniser is preset to 1. All outputs are 0: recv_valid, recv_busy, recv_overrun, recv_level, recv_data, recv_frame_err, recv_parity_err.
- rx passes through a 2-flop synchroniser; all logic below uses the synchronised value rxs.
- Tick counter is 4 bits and wraps every 16 ticks. Each bit is sampled at ticks 7, 8 and 9; the bit value is the majority of the three, decided at tick 9.
- States and transitions:
  - IDLE: rxs=0 -> START, tick counter=0, recv_busy=1.
  - START: majority=1 is a glitch -> IDLE, nothing pushed, no error. Majority=0 -> DATA at the next tick-0 boundary.
  - DATA: shifts DATA_BITS bits in LSB first -> PARITY if PARITY!=0, else STOP.
  - PARITY: parity_err = (XOR of data bits XOR the parity bit) != (PARITY==2). -> STOP.
  - STOP: each stop bit is sampled. A stop bit with majority 0 sets frame_err. With STOP_BITS=2 the first stop bit is checked, then the second.
- Completion happens at tick 9 of the last stop bit:
  - The word {data, frame_err, parity_err} is pushed.
  - frame_err=0 -> IDLE the next cycle. This allows back-to-back frames with a half-bit gap.
  - frame_err=1 -> BREAK_WAIT. recv_busy stays 1 until rxs=1, then IDLE. This prevents retriggering on a held-low line.
- Latency: 8N1 push happens 153 cycles after the START entry; recv_valid rises the following cycle.
- FIFO is first-word-fall-through: recv_data and the error flags show the head entry combinationally from registers. A pop happens on a clock edge with recv_read && recv_valid.
- Push into a full FIFO with no pop in the same cycle: the word is dropped and recv_overrun is set. Push and pop in the same cycle when full: both take effect, level is unchanged, no overrun. Push and pop when empty is not possible, since recv_valid=0.
- recv_overrun_clear together with a new overrun in the same cycle: set wins.
- Pointers are FIFO_DEPTH_LOG2 bits and wrap naturally. The level counter is one bit wider to tell full from empty.

Decomposition:
- Package uart_pkg holds:
  - parity mode constants PARITY_NONE/EVEN/ODD
  - OVERSAMPLE=16 and SAMPLE_T0/T1/T2 = 7/8/9
  - the rx state enum: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT
- Sub-module uart_sync_fifo is a generic FWFT FIFO parametrised by WIDTH and DEPTH_LOG2, with full/empty/level and overrun-free push/pop. It is instantiated with WIDTH=DATA_BITS+2.

Test Plan:
1. Default params, reset, send 8N1 0x56 then 0x77 at 16 clk/bit, recv_read held low -> level 2, head 0x56 with both error flags 0; pulse recv_read -> head 0x77.
2. rx low for 1 cycle, later for 5 cycles -> no push, level stays 0, recv_busy back to 0 within 12 cycles of each pulse.
3. DATA_BITS=7, PARITY=1: send 0x2B with parity bit 0 -> parity_err=0; send 0x2B with parity bit 1 -> data 0x2B, parity_err=1.
4. Send 0xAB with the stop bit low and rx held low 60 cycles, then high -> one entry 0xAB with frame_err=1; recv_busy high until rx returns high; no spurious second entry.
5. FIFO_DEPTH_LOG2=2, recv_read low, send 0x01..0x05 back-to-back -> level 4, recv_overrun=1, pops return 0x01..0x04; recv_overrun_clear -> 0. Then refill to full and pop in the same cycle as the next push -> level 4 and no overrun.
6. STOP_BITS=2: two back-to-back frames 0xFE, 0x00 -> both accepted. Assert reset mid-frame at bit 4 -> level 0, recv_busy 0; the next clean frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and types for the parametrised UART receive path.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  localparam int OVERSAMPLE = 16;

  localparam logic [3:0] SAMPLE_T0 = 4'd7;
  localparam logic [3:0] SAMPLE_T1 = 4'd8;
  localparam logic [3:0] SAMPLE_T2 = 4'd9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK_WAIT
  } rx_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic first-word-fall-through FIFO; a push into a full FIFO is dropped
// unless a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty     = (level == '0);
  assign full      = (level == LVL_FULL);
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  // Head is masked while empty so stale storage never leaks out.
  assign head_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !do_pop)      level <= level + LVL_ONE;
      else if (do_pop && !do_push) level <= level - LVL_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver: 16x oversampling with 3-sample majority vote,
// feeding a FWFT FIFO of {data, frame_err, parity_err} words.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS       = 8,
  parameter int PARITY          = 0,
  parameter int STOP_BITS       = 1,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                     clk_baud_16x,
  input  logic                     reset,
  input  logic                     rx,
  output logic [DATA_BITS-1:0]     recv_data,
  output logic                     recv_frame_err,
  output logic                     recv_parity_err,
  output logic                     recv_valid,
  input  logic                     recv_read,
  output logic                     recv_busy,
  output logic                     recv_overrun,
  input  logic                     recv_overrun_clear,
  output logic [FIFO_DEPTH_LOG2:0] recv_level
);

  localparam int         WORD_W     = DATA_BITS + 2;
  localparam logic [3:0] LAST_TICK  = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] DATA_LAST  = 4'(DATA_BITS);
  localparam logic       LAST_STOP  = 1'(STOP_BITS - 1);
  localparam logic       HAS_PARITY = (PARITY != PARITY_NONE);
  localparam logic       ODD_PARITY = (PARITY == PARITY_ODD);

  logic                 sync1;
  logic                 rxs;
  rx_state_t            state, state_nx;
  logic [3:0]           tick, tick_nx;
  logic [3:0]           bit_cnt, bit_cnt_nx;
  logic                 stop_idx, stop_idx_nx;
  logic                 s0, s1;
  logic [DATA_BITS-1:0] shreg, shreg_nx;
  logic                 frame_err, frame_err_nx;
  logic                 parity_err, parity_err_nx;
  logic                 maj;
  logic                 stop_err;
  logic                 bit_edge;
  logic                 bit_end;
  logic                 push;
  logic [WORD_W-1:0]    push_word;
  logic [WORD_W-1:0]    head_word;
  logic                 fifo_full;
  logic                 fifo_empty;

  always_ff @(posedge clk_baud_16x) begin
    if (reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx;
      rxs   <= sync1;
    end
  end

  assign maj       = majority3(s0, s1, rxs);
  assign stop_err  = frame_err | ~maj;
  assign bit_edge  = (tick == SAMPLE_T2);
  assign bit_end   = (tick == LAST_TICK);
  assign push_word = {shreg, stop_err, parity_err};

  always_ff @(posedge clk_baud_16x) begin
    if (reset) begin
      state      <= IDLE;
      tick       <= '0;
      bit_cnt    <= '0;
      stop_idx   <= 1'b0;
      s0         <= 1'b1;
      s1         <= 1'b1;
      shreg      <= '0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state      <= state_nx;
      tick       <= tick_nx;
      bit_cnt    <= bit_cnt_nx;
      stop_idx   <= stop_idx_nx;
      shreg      <= shreg_nx;
      frame_err  <= frame_err_nx;
      parity_err <= parity_err_nx;
      if (tick == SAMPLE_T0) s0 <= rxs;
      if (tick == SAMPLE_T1) s1 <= rxs;
    end
  end

  // Bits are decided at tick 9; state advances on the tick-15 boundary,
  // except the last stop bit which completes the word immediately.
  always_comb begin
    state_nx      = state;
    tick_nx       = tick + 4'd1;
    bit_cnt_nx    = bit_cnt;
    stop_idx_nx   = stop_idx;
    shreg_nx      = shreg;
    frame_err_nx  = frame_err;
    parity_err_nx = parity_err;
    push          = 1'b0;
    case (state)
      IDLE: begin
        tick_nx = '0;
        if (!rxs) begin
          state_nx      = START;
          bit_cnt_nx    = '0;
          stop_idx_nx   = 1'b0;
          frame_err_nx  = 1'b0;
          parity_err_nx = 1'b0;
        end
      end
      START: begin
        if (bit_edge && maj) state_nx = IDLE;
        else if (bit_end)    state_nx = DATA;
      end
      DATA: begin
        if (bit_edge) begin
          shreg_nx   = {maj, shreg[DATA_BITS-1:1]};
          bit_cnt_nx = bit_cnt + 4'd1;
        end
        if (bit_end && bit_cnt == DATA_LAST) begin
          if (HAS_PARITY) state_nx = uart_pkg::PARITY;
          else            state_nx = STOP;
        end
      end
      uart_pkg::PARITY: begin
        if (bit_edge) parity_err_nx = ((^shreg) ^ maj) != ODD_PARITY;
        if (bit_end)  state_nx = STOP;
      end
      STOP: begin
        if (bit_edge) begin
          frame_err_nx = stop_err;
          if (stop_idx == LAST_STOP) begin
            push     = 1'b1;
            state_nx = stop_err ? BREAK_WAIT : IDLE;
          end
        end else if (bit_end) begin
          stop_idx_nx = 1'b1;
        end
      end
      BREAK_WAIT: begin
        tick_nx = '0;
        if (rxs) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign recv_busy = (state != IDLE);

  uart_sync_fifo #(
    .WIDTH      (WORD_W),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk_baud_16x),
    .reset     (reset),
    .push      (push),
    .push_data (push_word),
    .pop       (recv_read),
    .head_data (head_word),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (recv_level)
  );

  assign recv_valid = !fifo_empty;
  assign {recv_data, recv_frame_err, recv_parity_err} = head_word;

  // A new overrun takes priority over a simultaneous clear.
  always_ff @(posedge clk_baud_16x) begin
    if (reset)                                                recv_overrun <= 1'b0;
    else if (push && fifo_full && !(recv_read && recv_valid)) recv_overrun <= 1'b1;
    else if (recv_overrun_clear)                              recv_overrun <= 1'b0;
  end

endmodule
